tick_bcd_stopwatch: RTL and testbench

//  Stopwatch that consumes the one-cycle tick pulse from the lab's periodic delay counter.

---
 rtl/tick_bcd_stopwatch.sv | 122 ++++++++++++
 tb/tb_tick_bcd_stopwatch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_bcd_stopwatch.sv
// BCD stopwatch driven by the delay-counter tick, with run/pause, clear and lap-hold buttons.
// display shows the lap snapshot while lap hold is active, otherwise the live count.
module tick_bcd_stopwatch #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  btn_run,
    input  logic                  btn_clear,
    input  logic                  btn_lap,
    output logic [4*DIGITS-1:0]   display,
    output logic                  running,
    output logic                  lap_active,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] lapReg_q;
    logic                lapActive_q;
    logic                overflow_q;
    logic                runHist_q;
    logic                clearHist_q;
    logic                lapHist_q;

    logic [4*DIGITS-1:0] countInc;
    logic                atMax;
    logic                carry;
    logic                runPress;
    logic                clearPress;
    logic                lapPress;

    assign runPress   = btn_run   & ~runHist_q;
    assign clearPress = btn_clear & ~clearHist_q;
    assign lapPress   = btn_lap   & ~lapHist_q;

    // Ripple a +1 through the digits; a carry out of the top digit means the count is all 9s.
    always_comb begin
        carry    = 1'b1;
        countInc = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    countInc[4*i +: 4] = 4'd0;
                end else begin
                    countInc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        atMax = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            lapReg_q    <= '0;
            lapActive_q <= 1'b0;
            overflow_q  <= 1'b0;
            // A button held through reset must not register as a press.
            runHist_q   <= 1'b1;
            clearHist_q <= 1'b1;
            lapHist_q   <= 1'b1;
        end else begin
            runHist_q   <= btn_run;
            clearHist_q <= btn_clear;
            lapHist_q   <= btn_lap;
            overflow_q  <= 1'b0;
            if (clearPress) begin
                state_q     <= IDLE;
                count_q     <= '0;
                lapReg_q    <= '0;
                lapActive_q <= 1'b0;
            end else begin
                if (state_q == RUN && tick) begin
                    if (atMax) begin
                        overflow_q <= 1'b1;
                        if (WRAP != 0) begin
                            count_q <= '0;
                        end else begin
                            state_q <= PAUSE;
                        end
                    end else begin
                        count_q <= countInc;
                    end
                end

                case (state_q)
                    IDLE:    if (runPress) state_q <= RUN;
                    RUN:     if (runPress) state_q <= PAUSE;
                    PAUSE:   if (runPress) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase

                // Snapshot uses the pre-increment count when a tick lands on the same edge.
                if (lapPress && state_q != IDLE) begin
                    if (!lapActive_q) begin
                        lapReg_q    <= count_q;
                        lapActive_q <= 1'b1;
                    end else begin
                        lapActive_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign display    = lapActive_q ? lapReg_q : count_q;
    assign running    = (state_q == RUN);
    assign lap_active = lapActive_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Self-checking bench for tick_bcd_stopwatch: a wrapping and a saturating instance share stimulus,
// a vector table covers the basic run/pause flow and a decimal reference model covers the rest.
module tb_tick_bcd_stopwatch;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                tick = 1'b0;
    logic                btnRun = 1'b0;
    logic                btnClear = 1'b0;
    logic                btnLap = 1'b0;
    logic [4*DIGITS-1:0] dispW, dispS;
    logic                runW, runS, lapW, lapS, ovfW, ovfS;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_bcd_stopwatch #(.DIGITS(DIGITS), .WRAP(1)) dutWrap (
        .clk(clk), .rst(rst), .tick(tick), .btn_run(btnRun), .btn_clear(btnClear),
        .btn_lap(btnLap), .display(dispW), .running(runW), .lap_active(lapW), .overflow(ovfW)
    );

    tick_bcd_stopwatch #(.DIGITS(DIGITS), .WRAP(0)) dutSat (
        .clk(clk), .rst(rst), .tick(tick), .btn_run(btnRun), .btn_clear(btnClear),
        .btn_lap(btnLap), .display(dispS), .running(runS), .lap_active(lapS), .overflow(ovfS)
    );

    // Reference model works in plain decimal; st: 0 idle, 1 run, 2 pause.
    typedef struct {
        int st;
        int cnt;
        int lapv;
        bit lapAct;
        bit ovf;
        bit hR;
        bit hC;
        bit hL;
    } model_t;

    typedef struct {
        logic [15:0] disp;
        bit          run;
        bit          lap;
        bit          ovf;
        int          inst;
        string       name;
    } exp_t;

    typedef struct {
        bit          t;
        bit          r;
        bit          c;
        bit          l;
        logic [15:0] disp;
        bit          run;
        bit          lap;
        bit          ovf;
    } vec_t;

    model_t mW, mS;
    exp_t   sb[$];
    vec_t   vecs[$];

    function automatic logic [15:0] toBcd(int v);
        logic [15:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(x % 10);
            x             = x / 10;
        end
        return res;
    endfunction

    function automatic model_t modelStep(model_t m, bit wrap, bit r, bit t, bit br, bit bc, bit bl);
        model_t n;
        bit     pr, pc, pl;
        n = m;
        if (r) begin
            n = '{st: 0, cnt: 0, lapv: 0, lapAct: 0, ovf: 0, hR: 1, hC: 1, hL: 1};
            return n;
        end
        pr    = br && !m.hR;
        pc    = bc && !m.hC;
        pl    = bl && !m.hL;
        n.hR  = br;
        n.hC  = bc;
        n.hL  = bl;
        n.ovf = 0;
        if (pc) begin
            n.st = 0; n.cnt = 0; n.lapv = 0; n.lapAct = 0;
            return n;
        end
        if (m.st == 1 && t) begin
            if (m.cnt == MAXV) begin
                n.ovf = 1;
                if (wrap) n.cnt = 0;
                else      n.st = 2;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end
        if (pr) n.st = (m.st == 1) ? 2 : 1;
        if (pl && m.st != 0) begin
            if (!m.lapAct) begin
                n.lapv   = m.cnt;
                n.lapAct = 1;
            end else begin
                n.lapAct = 0;
            end
        end
        return n;
    endfunction

    function automatic exp_t modelExp(model_t m, int inst, string name);
        exp_t e;
        e.disp = toBcd(m.lapAct ? m.lapv : m.cnt);
        e.run  = (m.st == 1);
        e.lap  = m.lapAct;
        e.ovf  = m.ovf;
        e.inst = inst;
        e.name = name;
        return e;
    endfunction

    function automatic vec_t mkVec(bit t, bit r, bit c, bit l, logic [15:0] d, bit ru, bit la, bit ov);
        vec_t v;
        v.t = t; v.r = r; v.c = c; v.l = l;
        v.disp = d; v.run = ru; v.lap = la; v.ovf = ov;
        return v;
    endfunction

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] aDisp;
        logic        aRun, aLap, aOvf;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                aDisp = dispW; aRun = runW; aLap = lapW; aOvf = ovfW;
            end else begin
                aDisp = dispS; aRun = runS; aLap = lapS; aOvf = ovfS;
            end
            checks++;
            if ({aDisp, aRun, aLap, aOvf} !== {e.disp, e.run, e.lap, e.ovf}) begin
                errors++;
                $display("[TB] FAIL %s inst=%0d got disp=%h run=%b lap=%b ovf=%b, expected disp=%h run=%b lap=%b ovf=%b",
                         e.name, e.inst, aDisp, aRun, aLap, aOvf, e.disp, e.run, e.lap, e.ovf);
            end
        end
    endtask

    task automatic driveAndStep(bit r, bit t, bit br, bit bc, bit bl);
        rst      = r;
        tick     = t;
        btnRun   = br;
        btnClear = bc;
        btnLap   = bl;
        mW = modelStep(mW, 1'b1, r, t, br, bc, bl);
        mS = modelStep(mS, 1'b0, r, t, br, bc, bl);
    endtask

    task automatic applyStimulus(string name, bit r, bit t, bit br, bit bc, bit bl, bit doCheck);
        driveAndStep(r, t, br, bc, bl);
        if (doCheck) begin
            sb.push_back(modelExp(mW, 0, name));
            sb.push_back(modelExp(mS, 1, name));
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyVector(vec_t v, string name);
        exp_t e;
        driveAndStep(1'b0, v.t, v.r, v.c, v.l);
        e.disp = v.disp; e.run = v.run; e.lap = v.lap; e.ovf = v.ovf; e.name = name;
        for (int k = 0; k < 2; k++) begin
            e.inst = k;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [15:0] tickExp [12];
        tickExp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                    16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};

        mW = '{st: 0, cnt: 0, lapv: 0, lapAct: 0, ovf: 0, hR: 1, hC: 1, hL: 1};
        mS = mW;

        // Idle ticks, then run, twelve ticks, pause, ticks ignored while paused.
        for (int i = 0; i < 40; i++) vecs.push_back(mkVec((i % 4) == 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 16'h0000, 1, 0, 0));
        for (int k = 0; k < 12; k++) begin
            vecs.push_back(mkVec(1, 0, 0, 0, tickExp[k], 1, 0, 0));
            vecs.push_back(mkVec(0, 0, 0, 0, tickExp[k], 1, 0, 0));
        end
        vecs.push_back(mkVec(0, 1, 0, 0, 16'h0012, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mkVec(1, 0, 0, 0, 16'h0012, 0, 0, 0));

        applyStimulus("reset", 1, 0, 0, 0, 0, 1);
        applyStimulus("reset2", 1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) applyVector(vecs[i], $sformatf("vec%0d", i));

        // BCD carry 99 -> 100, then roll to max and check wrap versus saturate.
        applyStimulus("clear", 0, 0, 0, 1, 0, 1);
        applyStimulus("clearRel", 0, 0, 0, 0, 0, 1);
        applyStimulus("runPress", 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 99; i++) applyStimulus("preload99", 0, 1, 0, 0, 0, 0);
        applyStimulus("at0099", 0, 0, 0, 0, 0, 1);
        applyStimulus("carry0100", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 9899; i++) applyStimulus("preloadMax", 0, 1, 0, 0, 0, 0);
        applyStimulus("at9999", 0, 0, 0, 0, 0, 1);
        applyStimulus("maxTick", 0, 1, 0, 0, 0, 1);
        applyStimulus("ovfDrop", 0, 0, 0, 0, 0, 1);
        applyStimulus("afterMaxTick", 0, 1, 0, 0, 0, 1);

        // Lap snapshot on the same edge as a tick, counting continues underneath.
        applyStimulus("clear2", 0, 0, 0, 1, 0, 1);
        applyStimulus("clear2Rel", 0, 0, 0, 0, 0, 1);
        applyStimulus("idleLapIgnored", 0, 0, 0, 0, 1, 1);
        applyStimulus("lapRel", 0, 0, 0, 0, 0, 1);
        applyStimulus("runPress2", 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus("count5", 0, 1, 0, 0, 0, 1);
        applyStimulus("lapWithTick", 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus("lapFrozen", 0, 1, 0, 0, 0, 1);
        applyStimulus("lapRelease", 0, 0, 0, 0, 1, 1);
        applyStimulus("lapRelLow", 0, 0, 0, 0, 0, 1);

        // Clear beats simultaneous tick and run press; run held through reset is not a press.
        for (int i = 0; i < 33; i++) applyStimulus("to0042", 0, 1, 0, 0, 0, 0);
        applyStimulus("at0042", 0, 0, 0, 0, 0, 1);
        applyStimulus("clearTickRun", 0, 1, 1, 1, 0, 1);
        applyStimulus("allLow", 0, 0, 0, 0, 0, 1);
        applyStimulus("rstRunHeld", 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus("runHeldAfterRst", 0, 1, 1, 0, 0, 1);
        applyStimulus("runRelease", 0, 0, 0, 0, 0, 1);

        // Reset mid-count with lap hold active.
        applyStimulus("runPress3", 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 317; i++) applyStimulus("to0317", 0, 1, 0, 0, 0, 0);
        applyStimulus("lapAt0317", 0, 0, 0, 0, 1, 1);
        applyStimulus("tickUnderLap", 0, 1, 0, 0, 0, 1);
        applyStimulus("rstMid", 1, 1, 0, 0, 1, 1);
        applyStimulus("afterRst", 0, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
